// File: rtl/gctr_combine.sv
// ---------------------------------------------------------------------------
// gctr_combine
//
// Purpose:
//   Final GCTR stage. Combines the text word leaving the plaintext delay line
//   with the AES keystream block of the same cycle. It XORs the two blocks,
//   zeroes the bytes past the block length, and queues the result in a
//   first-word-fall-through FIFO toward GHASH/egress. The AES pipeline cannot
//   stall, so backpressure is absorbed here. Upstream issue is throttled
//   through o_almost_full.
//
// Optional feature:
//   GCTR_BLOCK_CNT_EN - when defined, o_block_cnt counts popped blocks
//   (32-bit, wraps). When undefined, o_block_cnt is tied to 0.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active high
//   i_text[288:0]  [288] valid, [287] last, [286:282] nbytes,
//                  [281:256] seq id, [255:128] plaintext, [127:0] unused
//   i_keystream    AES keystream block
//   i_ks_valid     keystream valid
//   o_cipher       masked ciphertext at FIFO head (0 when empty)
//   o_nbytes       byte count of o_cipher, 1..16 (0 when empty)
//   o_seq          sequence id at FIFO head (0 when empty)
//   o_last         last-block flag at FIFO head (0 when empty)
//   o_valid        FIFO head holds a word
//   i_ready        downstream accepts the head word
//   o_almost_full  registered, occupancy >= AFULL_THRESH
//   o_align_err    sticky, text/keystream valid mismatch seen
//   o_ovf_err      sticky, word dropped because FIFO was full
//   o_block_cnt    emitted-block count (0 unless GCTR_BLOCK_CNT_EN)
// ---------------------------------------------------------------------------
module gctr_combine #(
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [288:0] i_text,
    input  logic [127:0] i_keystream,
    input  logic         i_ks_valid,
    output logic [127:0] o_cipher,
    output logic [4:0]   o_nbytes,
    output logic [25:0]  o_seq,
    output logic         o_last,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_almost_full,
    output logic         o_align_err,
    output logic         o_ovf_err,
    output logic [31:0]  o_block_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Entry layout: {cipher[127:0], nbytes[4:0], seq[25:0], last}
    localparam int EW = 128 + 5 + 26 + 1;

    logic [EW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic           r_almost_full;
    logic           r_align_err;
    logic           r_ovf_err;

    logic           w_text_vld;
    logic           w_last;
    logic [4:0]     w_nb_raw;
    logic [4:0]     w_nb;
    logic [25:0]    w_seq;
    logic [127:0]   w_pt;
    logic [127:0]   w_mask;
    logic [127:0]   w_cipher;
    logic           w_unused_text;

    logic           w_empty;
    logic           w_full;
    logic           w_req;
    logic           w_pop;
    logic           w_push;
    logic [PW-1:0]  w_wr_ptr_nxt;
    logic [PW-1:0]  w_rd_ptr_nxt;
    logic [PW-1:0]  w_occ_nxt;
    logic [EW-1:0]  w_head;

    // ------------------------------------------------------------------
    // Input field extraction and GCTR combine
    // ------------------------------------------------------------------
    assign w_text_vld    = i_text[288];
    assign w_last        = i_text[287];
    assign w_nb_raw      = i_text[286:282];
    assign w_seq         = i_text[281:256];
    assign w_pt          = i_text[255:128];
    assign w_unused_text = ^i_text[127:0];

    // A length of 0 or anything past 16 means a full block.
    assign w_nb = ((w_nb_raw == 5'd0) || (w_nb_raw > 5'd16)) ? 5'd16 : w_nb_raw;

    // Byte k sits at bits [127-8k -: 8] (big-endian). Keep it when k < nbytes.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < 16; k++) begin
            w_mask[127 - 8*k -: 8] = (5'(k) < w_nb) ? 8'hFF : 8'h00;
        end
    end

    assign w_cipher = (w_pt ^ i_keystream) & w_mask;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_req  = w_text_vld & i_ks_valid;
    assign w_pop  = ~w_empty & i_ready;
    // When full, a write is still accepted if the head leaves in the same
    // cycle. The head slot is read combinationally before the edge overwrites it.
    assign w_push = w_req & (~w_full | w_pop);

    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
    assign w_occ_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;

    // Storage is not reset. Outputs are gated by o_valid, so stale contents
    // never reach the port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_cipher, w_nb, w_seq, w_last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_almost_full <= 1'b0;
            r_align_err   <= 1'b0;
            r_ovf_err     <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_almost_full <= (w_occ_nxt >= PW'(AFULL_THRESH));
            if (w_text_vld ^ i_ks_valid) begin
                r_align_err <= 1'b1;
            end
            if (w_req && w_full && !w_pop) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    assign o_valid       = ~w_empty;
    assign o_cipher      = w_empty ? '0 : w_head[EW-1 -: 128];
    assign o_nbytes      = w_empty ? '0 : w_head[31:27];
    assign o_seq         = w_empty ? '0 : w_head[26:1];
    assign o_last        = w_empty ? 1'b0 : w_head[0];
    assign o_almost_full = r_almost_full;
    assign o_align_err   = r_align_err;
    assign o_ovf_err     = r_ovf_err;

`ifdef GCTR_BLOCK_CNT_EN
    logic [31:0] r_block_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_block_cnt <= '0;
        end else if (w_pop) begin
            r_block_cnt <= r_block_cnt + 32'd1;
        end
    end

    assign o_block_cnt = r_block_cnt;
`else
    assign o_block_cnt = '0;
`endif

endmodule

// File: tb/tb_gctr_combine.sv
module tb_gctr_combine;

    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [288:0] i_text;
    logic [127:0] i_keystream;
    logic         i_ks_valid;
    logic         i_ready;
    logic [127:0] o_cipher;
    logic [4:0]   o_nbytes;
    logic [25:0]  o_seq;
    logic         o_last;
    logic         o_valid;
    logic         o_almost_full;
    logic         o_align_err;
    logic         o_ovf_err;
    logic [31:0]  o_block_cnt;

    gctr_combine #(.DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_text        (i_text),
        .i_keystream   (i_keystream),
        .i_ks_valid    (i_ks_valid),
        .o_cipher      (o_cipher),
        .o_nbytes      (o_nbytes),
        .o_seq         (o_seq),
        .o_last        (o_last),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_almost_full (o_almost_full),
        .o_align_err   (o_align_err),
        .o_ovf_err     (o_ovf_err),
        .o_block_cnt   (o_block_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] c;
        logic [4:0]   nb;
        logic [25:0]  seq;
        logic         last;
    } ent_t;

    // Reference model: a queue of expected words plus the flags.
    ent_t        q[$];
    logic        m_align;
    logic        m_ovf;
    logic [31:0] m_cnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] PT  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] KS1 = {128{1'b1}};

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t model_word(logic [127:0] pt, logic [127:0] ks,
                                        logic [4:0] nb, logic [25:0] seq, logic last);
        ent_t e;
        int n;
        logic [127:0] ones;
        n = (nb == 0 || nb > 16) ? 16 : int'(nb);
        ones = '1;
        e.c = (pt ^ ks) & ~(ones >> (8*n));
        e.nb = 5'(n);
        e.seq = seq;
        e.last = last;
        return e;
    endfunction

    task automatic model_clear();
        q.delete();
        m_align = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic drive(input logic v, input logic ksv, input logic [4:0] nb,
                         input logic [25:0] seq, input logic last,
                         input logic [127:0] pt, input logic [127:0] ks);
        i_text      = {v, last, nb, seq, pt, {$urandom, $urandom, $urandom, $urandom}};
        i_keystream = ks;
        i_ks_valid  = ksv;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 26'd0, 1'b0, '0, '0);
    endtask

    task automatic check_all();
        chk("valid", 160'(o_valid), 160'(q.size() != 0));
        chk("afull", 160'(o_almost_full), 160'(q.size() >= AFT));
        chk("align", 160'(o_align_err), 160'(m_align));
        chk("ovf", 160'(o_ovf_err), 160'(m_ovf));
`ifdef GCTR_BLOCK_CNT_EN
        chk("blkcnt", 160'(o_block_cnt), 160'(m_cnt));
`else
        chk("blkcnt", 160'(o_block_cnt), 160'(0));
`endif
        if (q.size() != 0) begin
            chk("cipher", 160'(o_cipher), 160'(q[0].c));
            chk("nbytes", 160'(o_nbytes), 160'(q[0].nb));
            chk("seq", 160'(o_seq), 160'(q[0].seq));
            chk("last", 160'(o_last), 160'(q[0].last));
        end else begin
            chk("empty_data", {o_cipher, o_nbytes, o_seq, o_last}, 160'(0));
        end
    endtask

    // Advance the model by the current inputs, clock once, and check at negedge.
    task automatic tick();
        logic pop, req, was_full;
        pop      = (q.size() != 0) && i_ready;
        req      = i_text[288] && i_ks_valid;
        was_full = (q.size() == DEPTH);
        if (i_text[288] != i_ks_valid) m_align = 1'b1;
        if (pop) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 32'd1;
        end
        if (req) begin
            if (!was_full || pop)
                q.push_back(model_word(i_text[255:128], i_keystream, i_text[286:282],
                                       i_text[281:256], i_text[287]));
            else
                m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #1;
        check_all();
        chk("rst_valid", 160'(o_valid), 160'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst     = 1'b1;
        i_ready = 1'b0;
        idle();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("rst_outs", {o_cipher, o_nbytes, o_seq, o_last}, 160'(0));
        rst = 1'b0;

        // Single full block
        i_ready = 1'b1;
        drive(1'b1, 1'b1, 5'd16, 26'd5, 1'b1, PT, KS1);
        tick();
        chk("blk_valid", 160'(o_valid), 160'(1));
        chk("blk_cipher", 160'(o_cipher), 160'(128'hFFEEDDCC_BBAA9988_77665544_33221100));
        chk("blk_seq", 160'(o_seq), 160'(5));
        chk("blk_last", 160'(o_last), 160'(1));
        idle();
        tick();
        chk("blk_gone", 160'(o_valid), 160'(0));

        // Partial block, then nbytes=0 meaning a full block
        drive(1'b1, 1'b1, 5'd3, 26'd6, 1'b0, PT, KS1);
        tick();
        chk("part_cipher", 160'(o_cipher), 160'(128'hFFEEDD00_00000000_00000000_00000000));
        chk("part_nb", 160'(o_nbytes), 160'(3));
        drive(1'b1, 1'b1, 5'd0, 26'd7, 1'b0, PT, KS1);
        tick();
        chk("nb0_cipher", 160'(o_cipher), 160'(128'hFFEEDDCC_BBAA9988_77665544_33221100));
        chk("nb0_nb", 160'(o_nbytes), 160'(16));
        drive(1'b1, 1'b1, 5'd20, 26'd8, 1'b0, PT, KS1);
        tick();
        chk("nb20_nb", 160'(o_nbytes), 160'(16));
        idle();
        tick();

        // Backpressure and overflow
        i_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 5'd16, 26'(i), 1'b0, {$urandom, $urandom, $urandom, $urandom}, KS1);
            tick();
            if (i == 4) chk("afull_5", 160'(o_almost_full), 160'(0));
            if (i == 5) chk("afull_6", 160'(o_almost_full), 160'(1));
            if (i == 7) chk("ovf_8", 160'(o_ovf_err), 160'(0));
        end
        chk("ovf_9", 160'(o_ovf_err), 160'(1));
        idle();
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_seq", 160'(o_seq), 160'(i));
            tick();
        end
        chk("drain_empty", 160'(o_valid), 160'(0));

        // Full with simultaneous pop
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 5'd16, 26'(i), 1'b0, {$urandom, $urandom, $urandom, $urandom}, KS1);
            tick();
        end
        i_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("fpop_seq", 160'(o_seq), 160'(i));
            if (i == 0) drive(1'b1, 1'b1, 5'd16, 26'd8, 1'b0, PT, KS1);
            else idle();
            tick();
        end
        chk("fpop_empty", 160'(o_valid), 160'(0));
        chk("fpop_ovf", 160'(o_ovf_err), 160'(0));

        // Misalignment, then reset with words queued
        drive(1'b1, 1'b0, 5'd16, 26'd9, 1'b0, PT, KS1);
        tick();
        chk("mis_valid", 160'(o_valid), 160'(0));
        chk("mis_align", 160'(o_align_err), 160'(1));
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'd16, 26'(20 + i), 1'b0, PT, KS1);
            tick();
        end
        idle();
        do_reset();
        chk("rst_align", 160'(o_align_err), 160'(0));
        chk("rst_cnt", 160'(o_block_cnt), 160'(0));
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            i_ready = ($urandom_range(0, 99) < 45);
            if (r < 60)
                drive(1'b1, 1'b1, 5'($urandom_range(0, 31)), 26'($urandom), 1'($urandom),
                      {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom});
            else if (r < 62)
                drive(1'b0, 1'b1, 5'd16, 26'd0, 1'b0, PT, KS1);
            else
                idle();
            tick();
            if (n == 300) begin
                idle();
                do_reset();
            end
        end
        idle();
        i_ready = 1'b1;
        for (int n = 0; n < DEPTH + 2; n++) tick();
        chk("final_empty", 160'(o_valid), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gctr_combine.md
Name: gctr_combine

Overview:
- Consumes the 289-bit bypassed text word that leaves the 15-stage plaintext delay line, together with the AES keystream block produced in the same cycle.
- XORs plaintext with keystream (GCTR), masks bytes past the block length, and queues results in an output FIFO with a ready/valid interface toward GHASH/egress.
- The AES pipeline and delay line cannot stall, so backpressure is absorbed here and reported upstream through o_almost_full.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- AFULL_THRESH, 6, o_almost_full asserts when occupancy >= this value; must be < DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_text  in  289  bypassed word: [288] valid, [287] last, [286:282] nbytes, [281:256] seq id, [255:128] plaintext, [127:0] ignored.
- i_keystream  in  128  AES output block.
- i_ks_valid  in  1  keystream valid.
- o_cipher  out  128  masked ciphertext.
- o_nbytes  out  5  byte count of o_cipher (1..16).
- o_seq  out  26  seq id, passed through unchanged.
- o_last  out  1  last block of message.
- o_valid  out  1  output word available.
- i_ready  in  1  downstream accepts.
- o_almost_full  out  1  issue-throttle to upstream.
- o_align_err  out  1  sticky: text/keystream valid mismatch.
- o_ovf_err  out  1  sticky: write while full.
- o_block_cnt  out  32  emitted-block count (see Optional Feature).

Behaviour:
- Reset (async, active-high): FIFO empty; o_valid=0, o_almost_full=0, o_align_err=0, o_ovf_err=0, o_block_cnt=0. o_cipher, o_nbytes, o_seq and o_last read 0.
- Accept condition in cycle N is i_text[288] && i_ks_valid. The combined word is written to the FIFO at the closing edge of cycle N. If the FIFO was empty, o_valid is high in cycle N+1 (latency 1, first-word fall-through).
- Cipher: byte k (k=0 at bits [127:120], big-endian) = pt_k ^ ks_k for k < nbytes; otherwise 0x00.
- nbytes of 0 or >16 is treated as 16; o_nbytes then reports 16.
- Exactly one of i_text[288] / i_ks_valid high: the word is dropped and o_align_err sets (sticky until reset).
- Pop occurs when o_valid && i_ready. Outputs hold stable while o_valid && !i_ready.
- Write while full:
  - If a pop happens in the same cycle, the write is accepted and occupancy is unchanged.
  - Otherwise the word is dropped and o_ovf_err sets (sticky).
- Simultaneous write and pop when not full: occupancy unchanged, order preserved.
- Empty: o_valid=0; i_ready is ignored.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ, low bits equal.
- o_almost_full is registered and reflects occupancy after the current edge's updates.
- Reset asserted mid-stream: all queued words discarded immediately; no partial output after deassertion.

Optional Feature:
- Macro GCTR_BLOCK_CNT_EN.
- Defined: o_block_cnt is a 32-bit counter incremented on each pop. It wraps 0xFFFFFFFF -> 0 and resets to 0.
- Undefined: o_block_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Single full block: pt=0x00112233_44556677_8899AABB_CCDDEEFF, ks=0xFFFF...FF, nbytes=16, seq=5, last=1, i_ready=1 -> next cycle o_valid=1, o_cipher=0xFFEEDDCC_BBAA9988_77665544_33221100, o_seq=5, o_last=1; one cycle later o_valid=0.
- Partial block: same pt/ks, nbytes=3 -> o_cipher=0xFFEEDD00_00000000_00000000_00000000, o_nbytes=3. Repeat with nbytes=0 -> full 16-byte result, o_nbytes=16.
- Backpressure/full: i_ready=0, 9 consecutive accepted words (DEPTH=8):
  - o_almost_full rises after the 6th write.
  - 9th word dropped; o_ovf_err=1.
  - Then i_ready=1 -> exactly 8 words emerge in seq order 0..7.
- Full with simultaneous pop: FIFO holds 8 words, i_ready=1 while a 9th word arrives -> word accepted, o_ovf_err stays 0, 9 words delivered in order.
- Misalignment and reset: i_text valid with i_ks_valid=0 -> nothing queued, o_align_err=1. Then rst pulse with 3 words queued -> o_valid=0, errors cleared, o_block_cnt=0 (with GCTR_BLOCK_CNT_EN: count equals pops before reset, then 0).
